// File: rtl/mem_pkg.sv
// mem_pkg: load/store op encoding shared by EXE, MEM and WB
package mem_pkg;
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4,
    ST    = 3'd5
  } mem_op_t;
endpackage

// File: rtl/load_ext.sv
// load_ext: aligns bus read data by byte offset and sign/zero-extends per load op
module load_ext
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           data,
  input  mem_op_t                     op,
  input  logic [$clog2(DATA_W/8)-1:0] off,
  output logic [DATA_W-1:0]           ext
);
  logic [DATA_W-1:0] sh;
  always_comb begin
    sh  = data >> {off, 3'b000};
    ext = op == LD_W  ? sh :
          op == LD_H  ? DATA_W'($signed(sh[15:0])) :
          op == LD_HU ? DATA_W'(sh[15:0]) :
          op == LD_B  ? DATA_W'($signed(sh[7:0])) :
          op == LD_BU ? DATA_W'(sh[7:0]) : '0;
  end
endmodule

// File: rtl/mem_resp_queue.sv
// mem_resp_queue: in-order MEM response queue; flushed requests linger as ghosts until their data_ok drains
module mem_resp_queue
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int META_W = 38
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  mem_op_t                     req_op,
  input  logic [$clog2(DATA_W/8)-1:0] req_off,
  input  logic [META_W-1:0]           req_meta,
  input  logic                        data_ok,
  input  logic [DATA_W-1:0]           rdata,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [META_W-1:0]           out_meta,
  output logic                        out_is_load,
  output logic [$clog2(DEPTH):0]      outstanding,
  output logic                        proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DATA_W/8);
  localparam int PW = AW + 1;
  logic [PW-1:0]     wr_ptr, rsp_ptr, rd_ptr, count, wr_n, rsp_n, rd_n;
  logic [AW-1:0]     wi, si, ri;
  logic [DEPTH-1:0]  ghost, done;
  logic [DATA_W-1:0] data_q [DEPTH];
  mem_op_t           op_q   [DEPTH];
  logic [OW-1:0]     off_q  [DEPTH];
  logic [META_W-1:0] meta_q [DEPTH];
  logic              push, rsp_hit, head_live, head_done, pop;
  logic [DATA_W-1:0] head_raw, head_ext;
  // Pointers carry a wrap bit so rsp_ptr == wr_ptr unambiguously means nothing is awaiting data
  always_comb begin
    wi          = wr_ptr[AW-1:0];
    si          = rsp_ptr[AW-1:0];
    ri          = rd_ptr[AW-1:0];
    req_ready   = count < PW'(DEPTH);
    push        = req_valid & req_ready;
    rsp_hit     = data_ok & (rsp_ptr != wr_ptr);
    head_live   = (count != '0) & !ghost[ri];
    head_done   = done[ri] | (rsp_hit & (rsp_ptr == rd_ptr));
    out_valid   = head_live & head_done & !flush;
    pop         = (out_valid & out_ready) | ((count != '0) & ghost[ri] & head_done);
    wr_n        = wr_ptr + PW'(push);
    rsp_n       = rsp_ptr + PW'(rsp_hit);
    rd_n        = flush ? rsp_n : rd_ptr + PW'(pop);
    out_is_load = head_live & !flush & (op_q[ri] != ST);
    outstanding = count;
  end
  assign head_raw = done[ri] ? data_q[ri] : rdata;
  load_ext #(.DATA_W(DATA_W)) u_ext (.data(head_raw), .op(op_q[ri]), .off(off_q[ri]), .ext(head_ext));
  assign out_data = out_valid ? head_ext : '0;
  assign out_meta = out_valid ? meta_q[ri] : '0;
  // On flush every done entry sits between rd_ptr and rsp_ptr, so freeing them is a pointer jump
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rsp_ptr   <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ghost     <= '0;
      done      <= '0;
      proto_err <= 1'b0;
    end else begin
      wr_ptr    <= wr_n;
      rsp_ptr   <= rsp_n;
      rd_ptr    <= rd_n;
      count     <= wr_n - rd_n;
      proto_err <= proto_err | (data_ok & !rsp_hit);
      if (flush) ghost <= '1;
      if (rsp_hit) done[si] <= 1'b1;
      if (push) begin
        ghost[wi] <= flush;
        done[wi]  <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      op_q[wi]   <= req_op;
      off_q[wi]  <= req_off;
      meta_q[wi] <= req_meta;
    end
    if (rsp_hit) data_q[si] <= rdata;
  end
endmodule
